vga_controller: RTL and testbench
=================================

VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as below.
REQ-002 Parameter H_SYNC, default 96: horizontal sync pulse width in pixel clocks.
REQ-003 Parameter H_BACK, default 48: horizontal back porch. Parameter H_ACT, default 640: visible pixels. Parameter H_FRONT, default 16: horizontal front porch.
REQ-004 Parameter V_SYNC, default 2: vertical sync pulse width in lines. Parameter V_BACK, default 33: vertical back porch. Parameter V_ACT, default 480: visible lines. Parameter V_FRONT, default 10: vertical front porch.
REQ-005 iCLK  in  1  pixel clock, 25.175 MHz nominal, supplied by the external PLL (vgadll); all logic on the rising edge.
REQ-006 iRST  in  1  asynchronous reset, active-high.
REQ-007 iCursor_RGB_EN  in  4  channel enables: [2]=red, [1]=green, [0]=blue; [3] reserved, ignored.
REQ-008 iRed, iGreen, iBlue  in  10 each  pixel colour for the current oCoord_X/oCoord_Y.
REQ-009 oCoord_X, oCoord_Y  out  10 each  current visible pixel coordinate.
REQ-010 oVGA_R, oVGA_G, oVGA_B  out  10 each  colour to the DAC.
REQ-011 oVGA_H_SYNC, oVGA_V_SYNC  out  1 each  sync signals, active-low.
REQ-012 oVGA_SYNC  out  1  composite sync, constant 0.
REQ-013 oVGA_BLANK  out  1  active-low blank: 1 during visible video, 0 otherwise.

Function
REQ-014 H counter hc SHALL count 0..H_TOT-1, then wrap to 0; H_TOT = sum of the H parameters (default 800).
REQ-015 V counter vc SHALL advance only on the hc wrap from H_TOT-1 to 0; it counts 0..V_TOT-1 and wraps to 0; V_TOT defaults to 525.
REQ-016 H visible window SHALL be hc in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACT-1], default [144, 783].
REQ-017 V visible window SHALL be vc in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACT-1], default [35, 514].
REQ-018 Sync, blank and coordinate outputs SHALL be registered, reflecting the counter values of the previous cycle (one-cycle latency).
REQ-019 oVGA_H_SYNC SHALL be 0 exactly when hc < H_SYNC; oVGA_V_SYNC SHALL be 0 exactly when vc < V_SYNC.
REQ-020 oVGA_BLANK SHALL be 1 only when both hc and vc are inside their visible windows.
REQ-021 When visible, oCoord_X = hc-(H_SYNC+H_BACK) (range 0..639) and oCoord_Y = vc-(V_SYNC+V_BACK) (range 0..479).
REQ-022 When not visible, oCoord_X and oCoord_Y SHALL be 0.
REQ-023 Colour outputs SHALL be combinational from the inputs: oVGA_R = iRed when oVGA_BLANK=1 and iCursor_RGB_EN[2]=1, else 0; likewise G with [1] and B with [0].
REQ-024 Counter widths SHALL be 10 bits; no other arithmetic overflow is permitted.
REQ-025 Frame period SHALL be exactly 420000 clocks at default parameters.

Reset
REQ-026 While iRST=1: hc=0, vc=0, oVGA_H_SYNC=1, oVGA_V_SYNC=1, oVGA_BLANK=0, coordinates 0, RGB 0.
REQ-027 After release, counting SHALL start at the first rising edge.
REQ-028 Asserting reset mid-frame SHALL immediately force the REQ-026 values; after release the frame restarts from hc=0, vc=0.

Structure
REQ-029 Package vga_timing_pkg SHALL hold the default timing constants and the derived H_TOT, V_TOT and window bounds.
REQ-030 One sub-module, vga_axis_counter, is natural: a wrapping counter with sync, active and coordinate decode, instantiated once for H and once for V (V enabled by the H wrap).
REQ-031 to_seven_digit (4-bit hex to 7-segment decoder) and vgadll (PLL) SHALL be separate blocks outside this module.

Verification
REQ-032 Reset, then run 800 clocks -> H_SYNC low for exactly 96 clocks per line; line period exactly 800.
REQ-033 Run one full frame -> V_SYNC low for exactly 2 lines (1600 clocks); frame period exactly 420000 clocks.
REQ-034 Drive iRed=10'h3FF, iGreen=10'h155, iBlue=10'h2AA with enables 4'b0111 -> visible pixels output those values; blanking outputs 0.
REQ-035 Drive enables 4'b0101 -> oVGA_G=0 always; R and B pass through when visible.
REQ-036 Check the first visible pixel -> coordinates (0,0) with BLANK rising together; last visible pixel -> (639,479); next cycle BLANK=0 and coordinates 0.
REQ-037 Assert iRST mid-line for 3 cycles -> syncs high, BLANK=0 asynchronously; after release the frame timing restarts from (hc,vc)=(0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the derived totals and window bounds.
package vga_timing_pkg;
  localparam int CNT_W = 10;

  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_ACT_DEF   = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_ACT_DEF   = 480;
  localparam int V_FRONT_DEF = 10;

  localparam int H_TOT       = H_SYNC_DEF + H_BACK_DEF + H_ACT_DEF + H_FRONT_DEF;
  localparam int V_TOT       = V_SYNC_DEF + V_BACK_DEF + V_ACT_DEF + V_FRONT_DEF;
  localparam int H_ACT_START = H_SYNC_DEF + H_BACK_DEF;
  localparam int H_ACT_STOP  = H_ACT_START + H_ACT_DEF - 1;
  localparam int V_ACT_START = V_SYNC_DEF + V_BACK_DEF;
  localparam int V_ACT_STOP  = V_ACT_START + V_ACT_DEF - 1;

  function automatic logic [CNT_W-1:0] to_cnt(input int value);
    return value[CNT_W-1:0];
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping timing counter for one screen axis with sync, active-window and coordinate decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC  = H_SYNC_DEF,
  parameter int BACK  = H_BACK_DEF,
  parameter int ACT   = H_ACT_DEF,
  parameter int FRONT = H_FRONT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             wrap,
  output logic             sync_n,
  output logic             active,
  output logic [CNT_W-1:0] coord
);
  localparam logic [CNT_W-1:0] LAST      = to_cnt(SYNC + BACK + ACT + FRONT - 1);
  localparam logic [CNT_W-1:0] SYNC_END  = to_cnt(SYNC);
  localparam logic [CNT_W-1:0] ACT_START = to_cnt(SYNC + BACK);
  localparam logic [CNT_W-1:0] ACT_STOP  = to_cnt(SYNC + BACK + ACT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign wrap   = en && (cnt == LAST);
  assign sync_n = (cnt >= SYNC_END);
  assign active = (cnt >= ACT_START) && (cnt <= ACT_STOP);
  assign coord  = active ? cnt - ACT_START : '0;
endmodule

// File: rtl/vga_controller.sv
// VGA timing generator: H/V axis counters, registered sync/blank/coordinates, gated colour path.
module vga_controller
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [3:0] iCursor_RGB_EN,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [9:0] oCoord_X,
  output logic [9:0] oCoord_Y,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_H_SYNC,
  output logic       oVGA_V_SYNC,
  output logic       oVGA_SYNC,
  output logic       oVGA_BLANK
);
  logic             h_wrap, h_sync_n, h_active;
  logic             v_wrap, v_sync_n, v_active;
  logic [CNT_W-1:0] h_coord, v_coord;
  logic             visible;
  logic             unused;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BACK(H_BACK), .ACT(H_ACT), .FRONT(H_FRONT)
  ) u_h_axis (
    .clk(iCLK), .rst(iRST), .en(1'b1),
    .wrap(h_wrap), .sync_n(h_sync_n), .active(h_active), .coord(h_coord)
  );

  // The vertical axis only steps when the line counter wraps.
  vga_axis_counter #(
    .SYNC(V_SYNC), .BACK(V_BACK), .ACT(V_ACT), .FRONT(V_FRONT)
  ) u_v_axis (
    .clk(iCLK), .rst(iRST), .en(h_wrap),
    .wrap(v_wrap), .sync_n(v_sync_n), .active(v_active), .coord(v_coord)
  );

  assign visible = h_active && v_active;
  assign unused  = ^{iCursor_RGB_EN[3], v_wrap};

  // Output stage: one cycle behind the counters.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oVGA_H_SYNC <= 1'b1;
      oVGA_V_SYNC <= 1'b1;
      oVGA_BLANK  <= 1'b0;
      oCoord_X    <= '0;
      oCoord_Y    <= '0;
    end else begin
      oVGA_H_SYNC <= h_sync_n;
      oVGA_V_SYNC <= v_sync_n;
      oVGA_BLANK  <= visible;
      oCoord_X    <= visible ? h_coord : '0;
      oCoord_Y    <= visible ? v_coord : '0;
    end
  end

  assign oVGA_SYNC = 1'b0;
  assign oVGA_R    = (oVGA_BLANK && iCursor_RGB_EN[2]) ? iRed   : '0;
  assign oVGA_G    = (oVGA_BLANK && iCursor_RGB_EN[1]) ? iGreen : '0;
  assign oVGA_B    = (oVGA_BLANK && iCursor_RGB_EN[0]) ? iBlue  : '0;
endmodule

// File: tb/tb_vga_controller.sv
// Directed bench: a default-timing instance and a shrunken-timing instance share clock, reset and colour.
module tb_vga_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic [9:0] red, green, blue;

  logic [9:0] d_x, d_y, d_r, d_g, d_b;
  logic       d_hs, d_vs, d_sync, d_blank;
  logic [9:0] s_x, s_y, s_r, s_g, s_b;
  logic       s_hs, s_vs, s_sync, s_blank;

  int n;
  int cmp_cnt = 0;
  int err_cnt = 0;
  int d_hs_low, d_vs_low, s_vs_low;

  always #5 clk = ~clk;

  vga_controller u_dflt (
    .iCLK(clk), .iRST(rst), .iCursor_RGB_EN(en),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oCoord_X(d_x), .oCoord_Y(d_y),
    .oVGA_R(d_r), .oVGA_G(d_g), .oVGA_B(d_b),
    .oVGA_H_SYNC(d_hs), .oVGA_V_SYNC(d_vs), .oVGA_SYNC(d_sync), .oVGA_BLANK(d_blank)
  );

  // 32 clocks per line ([12,27] visible), 15 lines per frame ([5,12] visible).
  vga_controller #(
    .H_SYNC(8), .H_BACK(4), .H_ACT(16), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(3), .V_ACT(8), .V_FRONT(2)
  ) u_small (
    .iCLK(clk), .iRST(rst), .iCursor_RGB_EN(en),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oCoord_X(s_x), .oCoord_Y(s_y),
    .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
    .oVGA_H_SYNC(s_hs), .oVGA_V_SYNC(s_vs), .oVGA_SYNC(s_sync), .oVGA_BLANK(s_blank)
  );

  // Expected {hsync, vsync, blank, x, y} after n rising edges since reset release.
  function automatic logic [22:0] model(input int k, input int hsw, input int hbp, input int hac,
                                        input int hfp, input int vsw, input int vbp, input int vac,
                                        input int vfp);
    int ht, vt, hc, vc;
    logic vis;
    logic [9:0] x, y;
    if (k == 0) return {1'b1, 1'b1, 1'b0, 20'd0};
    ht  = hsw + hbp + hac + hfp;
    vt  = vsw + vbp + vac + vfp;
    hc  = (k - 1) % ht;
    vc  = ((k - 1) / ht) % vt;
    vis = (hc >= hsw + hbp) && (hc < hsw + hbp + hac) && (vc >= vsw + vbp) && (vc < vsw + vbp + vac);
    x   = vis ? 10'(hc - hsw - hbp) : 10'd0;
    y   = vis ? 10'(vc - vsw - vbp) : 10'd0;
    return {(hc >= hsw), (vc >= vsw), vis, x, y};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
    if (!d_hs) d_hs_low++;
    if (!d_vs) d_vs_low++;
    if (!s_vs) s_vs_low++;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    d_hs_low = 0;
    d_vs_low = 0;
    s_vs_low = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 4'b0111; red = 10'h3FF; green = 10'h155; blue = 10'h2AA;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({d_hs, d_vs, d_blank, d_sync} !== 4'b1100) begin
      err_cnt++; $display("FAIL reset_dflt_ctrl got %b want 1100", {d_hs, d_vs, d_blank, d_sync});
    end
    cmp_cnt++;
    if ({d_x, d_y} !== 20'd0) begin
      err_cnt++; $display("FAIL reset_dflt_coord got %0d,%0d want 0,0", d_x, d_y);
    end
    cmp_cnt++;
    if ({d_r, d_g, d_b} !== 30'd0) begin
      err_cnt++; $display("FAIL reset_dflt_rgb got %h want 0", {d_r, d_g, d_b});
    end
    cmp_cnt++;
    if ({s_hs, s_vs, s_blank, s_sync, s_x, s_y, s_r, s_g, s_b} !== {4'b1100, 50'd0}) begin
      err_cnt++; $display("FAIL reset_small got %h want %h",
        {s_hs, s_vs, s_blank, s_sync, s_x, s_y, s_r, s_g, s_b}, {4'b1100, 50'd0});
    end
  endtask

  task automatic test_hsync_default();
    int fall1, fall2, low800;
    logic prev;
    fall1 = -1; fall2 = -1; low800 = -1; prev = d_hs;
    for (int i = 0; i < 1601; i++) begin
      step();
      if (prev && !d_hs) begin
        if (fall1 < 0) fall1 = n;
        else if (fall2 < 0) fall2 = n;
      end
      prev = d_hs;
      if (n == 800) low800 = d_hs_low;
      if (n == 96) begin
        cmp_cnt++;
        if (d_hs !== 1'b0) begin err_cnt++; $display("FAIL hsync_last_low got %b want 0", d_hs); end
      end
      if (n == 97) begin
        cmp_cnt++;
        if (d_hs !== 1'b1) begin err_cnt++; $display("FAIL hsync_rise got %b want 1", d_hs); end
      end
    end
    cmp_cnt++;
    if (fall1 !== 1) begin err_cnt++; $display("FAIL hsync_first_fall got %0d want 1", fall1); end
    cmp_cnt++;
    if (low800 !== 96) begin err_cnt++; $display("FAIL hsync_width got %0d want 96", low800); end
    cmp_cnt++;
    if (fall2 - fall1 !== 800) begin
      err_cnt++; $display("FAIL line_period got %0d want 800", fall2 - fall1);
    end
  endtask

  task automatic test_vsync_default();
    steps(2400 - n);
    cmp_cnt++;
    if (d_vs_low !== 1600) begin err_cnt++; $display("FAIL vsync_width got %0d want 1600", d_vs_low); end
    cmp_cnt++;
    if (d_vs !== 1'b1) begin err_cnt++; $display("FAIL vsync_high got %b want 1", d_vs); end
  endtask

  task automatic test_first_last_pixel();
    steps(28144 - n);
    cmp_cnt++;
    if ({d_blank, d_x, d_y, d_r} !== 31'd0) begin
      err_cnt++; $display("FAIL pre_first_pixel got blank=%b x=%0d y=%0d r=%h want 0", d_blank, d_x, d_y, d_r);
    end
    step();
    cmp_cnt++;
    if ({d_blank, d_x, d_y} !== 21'h100000) begin
      err_cnt++; $display("FAIL first_pixel got blank=%b x=%0d y=%0d want 1,0,0", d_blank, d_x, d_y);
    end
    cmp_cnt++;
    if ({d_r, d_g, d_b} !== {10'h3FF, 10'h155, 10'h2AA}) begin
      err_cnt++; $display("FAIL first_pixel_rgb got %h/%h/%h want 3ff/155/2aa", d_r, d_g, d_b);
    end
    steps(28784 - n);
    cmp_cnt++;
    if ({d_blank, d_x, d_y} !== {1'b1, 10'd639, 10'd0}) begin
      err_cnt++; $display("FAIL last_pixel_line got blank=%b x=%0d y=%0d want 1,639,0", d_blank, d_x, d_y);
    end
    step();
    cmp_cnt++;
    if ({d_blank, d_x, d_y, d_r, d_g, d_b} !== 51'd0) begin
      err_cnt++; $display("FAIL after_last_pixel got blank=%b x=%0d y=%0d rgb=%h want all 0",
        d_blank, d_x, d_y, {d_r, d_g, d_b});
    end
  endtask

  task automatic test_enable_mask();
    steps(28950 - n);
    cmp_cnt++;
    if ({d_blank, d_x, d_y} !== {1'b1, 10'd5, 10'd1}) begin
      err_cnt++; $display("FAIL pixel_5_1 got blank=%b x=%0d y=%0d want 1,5,1", d_blank, d_x, d_y);
    end
    en = 4'b0101; #1;
    cmp_cnt++;
    if ({d_r, d_g, d_b} !== {10'h3FF, 10'h000, 10'h2AA}) begin
      err_cnt++; $display("FAIL en_0101 got %h/%h/%h want 3ff/000/2aa", d_r, d_g, d_b);
    end
    red = 10'h001; #1;
    cmp_cnt++;
    if (d_r !== 10'h001) begin err_cnt++; $display("FAIL red_comb got %h want 001", d_r); end
    en = 4'b1000; #1;
    cmp_cnt++;
    if ({d_r, d_g, d_b} !== 30'd0) begin
      err_cnt++; $display("FAIL en_1000 got %h/%h/%h want 0/0/0", d_r, d_g, d_b);
    end
    en = 4'b1111; #1;
    cmp_cnt++;
    if ({d_r, d_g, d_b} !== {10'h001, 10'h155, 10'h2AA}) begin
      err_cnt++; $display("FAIL en_1111 got %h/%h/%h want 001/155/2aa", d_r, d_g, d_b);
    end
    red = 10'h3FF; en = 4'b0111;
  endtask

  task automatic test_midline_reset();
    cmp_cnt++;
    if (d_blank !== 1'b1) begin err_cnt++; $display("FAIL pre_reset_visible got %b want 1", d_blank); end
    #2 rst = 1'b1;
    #1;
    cmp_cnt++;
    if ({d_hs, d_vs, d_blank, d_x, d_y, d_r, d_g, d_b} !== {3'b110, 50'd0}) begin
      err_cnt++; $display("FAIL async_reset got hs=%b vs=%b blank=%b x=%0d r=%h want 1,1,0,0,0",
        d_hs, d_vs, d_blank, d_x, d_r);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp_cnt++;
    if ({d_hs, d_vs, d_blank, s_hs, s_vs, s_blank} !== 6'b110110) begin
      err_cnt++; $display("FAIL reset_hold got %b want 110110", {d_hs, d_vs, d_blank, s_hs, s_vs, s_blank});
    end
    release_reset();
  endtask

  task automatic test_small_frames();
    logic [22:0] exp;
    logic [29:0] exp_rgb;
    int fall1, fall2;
    logic prev;
    fall1 = -1; fall2 = -1; prev = s_vs;
    for (int i = 0; i < 960; i++) begin
      step();
      exp = model(n, 8, 4, 16, 4, 2, 3, 8, 2);
      exp_rgb = exp[20] ? {red, green, 10'h000} : 30'd0;
      cmp_cnt++;
      if ({s_hs, s_vs, s_blank, s_x, s_y} !== exp) begin
        err_cnt++;
        if (err_cnt < 20) $display("FAIL small_timing n=%0d got %h want %h", n, {s_hs, s_vs, s_blank, s_x, s_y}, exp);
      end
      if (n == 1) begin
        en = 4'b0110;
        cmp_cnt++;
        if ({d_hs, d_vs} !== 2'b00) begin
          err_cnt++; $display("FAIL restart_syncs got %b want 00", {d_hs, d_vs});
        end
      end
      if (n > 1) begin
        cmp_cnt++;
        if ({s_r, s_g, s_b} !== exp_rgb) begin
          err_cnt++;
          if (err_cnt < 20) $display("FAIL small_rgb n=%0d got %h want %h", n, {s_r, s_g, s_b}, exp_rgb);
        end
      end
      if (n == 97) begin
        cmp_cnt++;
        if (d_hs !== 1'b1) begin err_cnt++; $display("FAIL restart_hsync_rise got %b want 1", d_hs); end
      end
      if (n == 412) begin
        cmp_cnt++;
        if ({s_blank, s_x, s_y} !== {1'b1, 10'd15, 10'd7}) begin
          err_cnt++; $display("FAIL small_last_pixel got blank=%b x=%0d y=%0d want 1,15,7", s_blank, s_x, s_y);
        end
      end
      if (n == 413) begin
        cmp_cnt++;
        if ({s_blank, s_x, s_y} !== 21'd0) begin
          err_cnt++; $display("FAIL small_after_last got blank=%b x=%0d y=%0d want 0,0,0", s_blank, s_x, s_y);
        end
      end
      if (prev && !s_vs) begin
        if (fall1 < 0) fall1 = n;
        else if (fall2 < 0) fall2 = n;
      end
      prev = s_vs;
    end
    cmp_cnt++;
    if (s_vs_low !== 128) begin err_cnt++; $display("FAIL small_vsync_width got %0d want 128", s_vs_low); end
    cmp_cnt++;
    if (fall2 - fall1 !== 480) begin
      err_cnt++; $display("FAIL small_frame_period got %0d want 480", fall2 - fall1);
    end
    en = 4'b0111;
  endtask

  initial begin
    test_reset();
    release_reset();
    test_hsync_default();
    test_vsync_default();
    test_first_last_pixel();
    test_enable_mask();
    test_midline_reset();
    test_small_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
